// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants and FSM state encoding for the TX and RX paths.
package uart_pkg;
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} uart_state_e;
    localparam int UART_DATA_BITS = 8;
    localparam int UART_FRAME_BITS = 11;
    localparam int UART_CLKS_PER_BIT = 5208;
    localparam logic UART_IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter; bit_end strobes on the last cycle of each bit period.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = uart_pkg::UART_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic bit_end
);
    localparam int W = $clog2(CLKS_PER_BIT);
    localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
    logic [W-1:0] cnt;
    assign bit_end = en && cnt == LAST;
    always_ff @(posedge clk) begin
        if (rst || clr || bit_end) cnt <= '0;
        else if (en) cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/uart_tx_parity.sv
// uart_tx_parity: UART transmitter, start + 8 data bits LSB-first + parity + stop.
// tx is registered from the current state, so the line lags the FSM by one cycle.
module uart_tx_parity
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_done
);
    localparam int IW = $clog2(UART_DATA_BITS);
    uart_state_e state;
    logic [UART_DATA_BITS-1:0] sh;
    logic [IW-1:0] idx;
    logic par;
    logic bit_end;
    logic accept;
    assign tx_ready = state == ST_IDLE && !rst;
    assign accept = tx_valid && tx_ready;
    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk(clk),
        .rst(rst),
        .clr(accept),
        .en(state != ST_IDLE),
        .bit_end(bit_end)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            tx <= UART_IDLE_LEVEL;
            tx_done <= 1'b0;
            sh <= '0;
            idx <= '0;
            par <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx <= state == ST_START ? 1'b0 :
                  state == ST_DATA ? sh[0] :
                  state == ST_PARITY ? par : UART_IDLE_LEVEL;
            case (state)
                ST_IDLE: if (accept) begin
                    sh <= tx_data;
                    par <= ^tx_data ^ PARITY_ODD;
                    idx <= '0;
                    state <= ST_START;
                end
                ST_START: if (bit_end) state <= ST_DATA;
                ST_DATA: if (bit_end) begin
                    sh <= sh >> 1;
                    idx <= idx + IW'(1);
                    if (idx == IW'(UART_DATA_BITS - 1)) state <= ST_PARITY;
                end
                ST_PARITY: if (bit_end) state <= ST_STOP;
                ST_STOP: if (bit_end) begin
                    state <= ST_IDLE;
                    tx_done <= 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_parity.sv
// tb_uart_tx_parity: directed frames for uart_tx_parity at CLKS_PER_BIT=4, even parity.
// Frames are given as 11-bit constants, bit 0 = start bit, bit 10 = stop bit.
module tb_uart_tx_parity;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic tx_valid = 1'b0;
    logic tx_ready;
    logic tx;
    logic tx_done;
    int n_checks = 0;
    int n_fail = 0;

    uart_tx_parity #(.CLKS_PER_BIT(4), .PARITY_ODD(1'b0)) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx(tx),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a byte, wait (bounded) for ready, return just after the accept edge.
    task automatic send(input logic [7:0] b, input bit hold);
        @(negedge clk);
        tx_data = b;
        tx_valid = 1'b1;
        for (int i = 0; i < 100 && !tx_ready; i++) @(negedge clk);
        if (!tx_ready) check("ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    // Called right after the accept edge; checks cycles 0..44 after it.
    task automatic check_frame(input logic [10:0] f, input string tag);
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            check($sformatf("%s tx c%0d", tag, k), tx, k == 0 ? 1'b1 : f[(k - 1) / 4]);
            check($sformatf("%s done/ready c%0d", tag, k), {tx_done, tx_ready}, k == 44 ? 2'b11 : 2'b00);
        end
    endtask

    task automatic check_idle(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check($sformatf("%s c%0d", tag, k), {tx, tx_ready, tx_done}, 3'b110);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset tx/ready/done", {tx, tx_ready, tx_done}, 3'b100);
        @(posedge clk);
        #1 rst = 1'b0;
        check_idle(20, "idle");

        send(8'h01, 0);
        check_frame(11'b11000000010, "f01");
        send(8'h03, 0);
        check_frame(11'b10000000110, "f03");
        send(8'h10, 0);
        check_frame(11'b11000100000, "f10");

        // tx_valid held across two frames; the data change during frame 0x0A must be ignored
        send(8'h0A, 1);
        tx_data = 8'h0B;
        check_frame(11'b10000010100, "f0A");
        @(posedge clk);
        #1 tx_valid = 1'b0;
        check_frame(11'b11000010110, "f0B");

        send(8'h05, 0);
        fork
            check_frame(11'b10000001010, "f05");
            begin
                repeat (10) @(posedge clk);
                #1;
                tx_data = 8'hFF;
                tx_valid = 1'b1;
                @(posedge clk);
                #1;
                tx_valid = 1'b0;
                tx_data = 8'h00;
            end
        join
        check_idle(8, "after f05");

        send(8'h0F, 0);
        repeat (17) @(negedge clk);
        rst = 1'b1;
        #1 check("ready during rst", tx_ready, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        check_idle(10, "after abort");
        send(8'h02, 0);
        check_frame(11'b11000000100, "f02");

        @(negedge clk);
        rst = 1'b1;
        tx_valid = 1'b1;
        tx_data = 8'h55;
        @(posedge clk);
        #1;
        rst = 1'b0;
        tx_valid = 1'b0;
        check_idle(6, "rst beats valid");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
